alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the team's combinational ALU. Accepts one operation per transaction on a valid/ready input, executes single-cycle ops in one clock and divide/modulo on an iterative N-cycle divider, and holds the 2N-bit result in a one-entry output register with its own valid/ready handshake. It sits between an operand issue stage and a result consumer that may stall.

## Interface
- N, 8: operand width, N ≥ 2; result width is 2N.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/op transaction offered.
- in_ready  out  1  block can accept this cycle.
- operand1, operand2  in  N  unsigned operands.
- operation  in  4  opcode, encoding below.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer takes the result this cycle.
- alu_out  out  2N  result.
- div_zero  out  1  result came from a divide or modulo by zero; valid with out_valid.

## Operation
- Opcodes, all results zero-extended to 2N unless stated:
  - 0: op1+op2 (carry lands in bit N).
  - 1: op1−op2, modulo 2^2N; a borrow gives upper bits all 1.
  - 2: op1*op2.
  - 3: op1/op2.
  - 4: op1%op2.
  - 5/6/7: bitwise AND/OR/XOR.
  - 8/9: logical AND/OR (0 or 1).
  - A: op1<<1 (bit N keeps the shifted-out MSB).
  - B: op1>>1.
  - C/D/E/F: ==, !=, <, > (0 or 1).
- Transaction accepted when in_valid && in_ready; operands and opcode are captured in that cycle.
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational from state and the output handshake.
- FSM states:
  - IDLE to IDLE: accept a non-divide op; the result is written to the output register.
  - IDLE to DIV: accept opcode 3/4 with operand2≠0; the divider starts.
  - DIV to DIV: divider has not finished.
  - DIV to IDLE: after exactly N iterations the quotient/remainder is written, out_valid←1, div_zero←0. In DIV, in_ready=0.
- Divide by zero (operand2==0, opcode 3/4) is not iterated; it completes like a single-cycle op.
  - Opcode 3: alu_out = {N'0, N'1s}.
  - Opcode 4: alu_out = zero-extended op1.
  - div_zero=1.
- out_valid is cleared when out_ready && out_valid, unless a new result is written in the same cycle; the write wins.
- alu_out and div_zero hold steady while out_valid && !out_ready.
- Reset at any point, including mid-DIV, aborts the operation.
  - Reset state: IDLE, out_valid=0, alu_out=0, div_zero=0, divider state cleared, in_ready=1 on release.

## Timing
- Acceptance at edge t. Non-divide ops and divide-by-zero: out_valid=1 from t+1.
- Divide/modulo, nonzero divisor: out_valid=1 from t+N+1.
- Back-to-back single-cycle ops with out_ready held high: one accept per cycle, full throughput.
- Output stalled (out_valid && !out_ready): in_ready=0, and no new transaction is taken.
- Divider is restoring, one quotient bit per cycle, N-bit remainder plus 1 guard bit.

## Structure
- Package alu_pkg:
  - op_e enum for the 16 opcodes.
  - state_e {IDLE, DIV}.
  - localparam DIV0_QUOT for the divide-by-zero quotient pattern.
- Sub-module alu_divider (parameter N):
  - Inputs: start, dividend, divisor.
  - Outputs: done, quotient, remainder.
  - Shares clk/rst and is reset identically.
- Top level holds the FSM, the single-cycle datapath and the output register.

## Test plan
- N=8, reset asserted mid-stream, then released → out_valid=0, alu_out=0, div_zero=0, in_ready=1.
- ADD 0xFF+0x01, out_ready=1 → alu_out=0x0100 at t+1. SUB 0x01−0x02 → 0xFFFF. MUL 0xFF*0xFF → 0xFE01.
- DIV 200/7 → alu_out=28 exactly at t+9, with in_ready=0 for cycles t+1..t+8. MOD 200/7 → 4.
- DIV 5/0 → alu_out=0x00FF, div_zero=1 at t+1. MOD 5/0 → 0x0005, div_zero=1.
- Hold out_ready=0 after an ADD → alu_out stable, in_ready=0. Then pulse out_ready together with in_valid (XOR 0xF0^0x3C) → the next cycle shows 0x00CC with no lost or duplicated result.
- Start DIV 255/3, assert rst at t+4 → FSM returns to IDLE, out_valid=0. The next ADD 1+1 → 0x0002 at t+1 after acceptance.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: opcodes, FSM states,
// and the quotient pattern returned on divide-by-zero.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_MOD  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_LAND = 4'h8,
    OP_LOR  = 4'h9,
    OP_SHL  = 4'hA,
    OP_SHR  = 4'hB,
    OP_EQ   = 4'hC,
    OP_NE   = 4'hD,
    OP_LT   = 4'hE,
    OP_GT   = 4'hF
  } op_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_e;

  // All-ones low half; the top level slices N bits (N up to 64)
  localparam logic [63:0] DIV0_QUOT = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand issue and result handshake bundle for alu_seq.
// master = issue stage plus result consumer, slave = the ALU.
interface alu_seq_if #(parameter int N = 8);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   operand1;
  logic [N-1:0]   operand2;
  logic [3:0]     operation;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] alu_out;
  logic           div_zero;

  modport master (
    output in_valid, operand1, operand2, operation, out_ready,
    input  in_ready, out_valid, alu_out, div_zero
  );

  modport slave (
    input  in_valid, operand1, operand2, operation, out_ready,
    output in_ready, out_valid, alu_out, div_zero
  );
endinterface

// File: rtl/alu_divider.sv
// Restoring divider, one quotient bit per clock. done, quotient and remainder
// are presented combinationally during the final iteration.
module alu_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
);

  localparam int CW = $clog2(N + 1);

  logic          busy_r;
  logic [CW-1:0] cnt_r;
  logic [N-1:0]  rem_r;
  logic [N-1:0]  quo_r;
  logic [N-1:0]  dvs_r;

  logic [N:0]    shifted_s;
  logic [N-1:0]  rem_n_s;
  logic [N-1:0]  quo_n_s;

  // One restoring step; shifted_s carries the guard bit above the remainder
  always_comb begin
    shifted_s = {rem_r, quo_r[N-1]};
    if (shifted_s >= {1'b0, dvs_r}) begin
      rem_n_s = N'(shifted_s - {1'b0, dvs_r});
      quo_n_s = {quo_r[N-2:0], 1'b1};
    end else begin
      rem_n_s = shifted_s[N-1:0];
      quo_n_s = {quo_r[N-2:0], 1'b0};
    end
  end

  // Iteration state: load on start, then shift/subtract for N cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      cnt_r  <= {CW{1'b0}};
      rem_r  <= {N{1'b0}};
      quo_r  <= {N{1'b0}};
      dvs_r  <= {N{1'b0}};
    end else if (start) begin
      busy_r <= 1'b1;
      cnt_r  <= {CW{1'b0}};
      rem_r  <= {N{1'b0}};
      quo_r  <= dividend;
      dvs_r  <= divisor;
    end else if (busy_r) begin
      rem_r  <= rem_n_s;
      quo_r  <= quo_n_s;
      cnt_r  <= cnt_r + CW'(1);
      busy_r <= (cnt_r != CW'(N - 1));
    end else begin
      busy_r <= busy_r;
    end
  end

  assign done      = busy_r && (cnt_r == CW'(N - 1));
  assign quotient  = quo_n_s;
  assign remainder = rem_n_s;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops complete at acceptance, divide/modulo run
// on alu_divider; results sit in a one-entry output register.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);

  localparam int W = 2 * N;

  state_e       state_r;
  state_e       state_n_s;
  logic         out_valid_r;
  logic [W-1:0] alu_out_r;
  logic         div_zero_r;
  logic         is_mod_r;

  op_e          op_s;
  logic         accept_s;
  logic         div_op_s;
  logic         b_zero_s;
  logic         start_s;
  logic         wr_s;
  logic         wr_dz_s;
  logic [W-1:0] wr_data_s;
  logic [W-1:0] single_s;
  logic [W-1:0] a_s;
  logic [W-1:0] b_s;
  logic         div_done_s;
  logic [N-1:0] quot_s;
  logic [N-1:0] rem_s;

  assign op_s         = op_e'(bus.operation);
  assign bus.in_ready = (state_r == IDLE) && (!out_valid_r || bus.out_ready);
  assign accept_s     = bus.in_valid && bus.in_ready;
  assign div_op_s     = is_div_op(op_s);
  assign b_zero_s     = (bus.operand2 == {N{1'b0}});

  // Single-cycle datapath; the divide/modulo arms cover only a zero divisor
  always_comb begin
    a_s = W'(bus.operand1);
    b_s = W'(bus.operand2);
    case (op_s)
      OP_ADD:  single_s = a_s + b_s;
      OP_SUB:  single_s = a_s - b_s;
      OP_MUL:  single_s = a_s * b_s;
      OP_DIV:  single_s = W'(DIV0_QUOT[N-1:0]);
      OP_MOD:  single_s = a_s;
      OP_AND:  single_s = a_s & b_s;
      OP_OR:   single_s = a_s | b_s;
      OP_XOR:  single_s = a_s ^ b_s;
      OP_LAND: single_s = W'((bus.operand1 != {N{1'b0}}) && !b_zero_s);
      OP_LOR:  single_s = W'((bus.operand1 != {N{1'b0}}) || !b_zero_s);
      OP_SHL:  single_s = W'({bus.operand1, 1'b0});
      OP_SHR:  single_s = W'(bus.operand1 >> 1'b1);
      OP_EQ:   single_s = W'(bus.operand1 == bus.operand2);
      OP_NE:   single_s = W'(bus.operand1 != bus.operand2);
      OP_LT:   single_s = W'(bus.operand1 < bus.operand2);
      OP_GT:   single_s = W'(bus.operand1 > bus.operand2);
      default: single_s = {W{1'b0}};
    endcase
  end

  // Next-state and result-write decode
  always_comb begin
    state_n_s = state_r;
    start_s   = 1'b0;
    wr_s      = 1'b0;
    wr_dz_s   = 1'b0;
    wr_data_s = single_s;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (div_op_s && !b_zero_s) begin
            state_n_s = DIV;
            start_s   = 1'b1;
          end else begin
            wr_s    = 1'b1;
            wr_dz_s = div_op_s;
          end
        end else begin
          state_n_s = IDLE;
        end
      end
      DIV: begin
        if (div_done_s) begin
          wr_s      = 1'b1;
          wr_data_s = is_mod_r ? W'(rem_s) : W'(quot_s);
          state_n_s = IDLE;
        end else begin
          state_n_s = DIV;
        end
      end
      default: state_n_s = IDLE;
    endcase
  end

  // FSM state and the divide/modulo selector captured at acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      is_mod_r <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      is_mod_r <= start_s ? (op_s == OP_MOD) : is_mod_r;
    end
  end

  // Output register: a new write wins over a same-cycle consume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      alu_out_r   <= {W{1'b0}};
      div_zero_r  <= 1'b0;
    end else if (wr_s) begin
      out_valid_r <= 1'b1;
      alu_out_r   <= wr_data_s;
      div_zero_r  <= wr_dz_s;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.alu_out   = alu_out_r;
  assign bus.div_zero  = div_zero_r;

  alu_divider #(.N(N)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (start_s),
    .dividend  (bus.operand1),
    .divisor   (bus.operand2),
    .done      (div_done_s),
    .quotient  (quot_s),
    .remainder (rem_s)
  );

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (N=8): directed table, handshake/reset
// sequences, and random transactions against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.N(N)) bus();

  alu_seq #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    logic        dz;
    logic [3:0]  lat;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, {div_zero, 16-bit result}
  function automatic logic [16:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int unsigned ai = a;
    int unsigned bi = b;
    int unsigned r = 0;
    logic dz = 1'b0;
    case (op)
      4'd0:  r = ai + bi;
      4'd1:  r = ai - bi;
      4'd2:  r = ai * bi;
      4'd3:  if (bi == 0) begin r = 255; dz = 1'b1; end else r = ai / bi;
      4'd4:  if (bi == 0) begin r = ai; dz = 1'b1; end else r = ai % bi;
      4'd5:  r = ai & bi;
      4'd6:  r = ai | bi;
      4'd7:  r = ai ^ bi;
      4'd8:  r = (ai != 0 && bi != 0) ? 1 : 0;
      4'd9:  r = (ai != 0 || bi != 0) ? 1 : 0;
      4'd10: r = ai * 2;
      4'd11: r = ai / 2;
      4'd12: r = (ai == bi) ? 1 : 0;
      4'd13: r = (ai != bi) ? 1 : 0;
      4'd14: r = (ai < bi) ? 1 : 0;
      4'd15: r = (ai > bi) ? 1 : 0;
      default: r = 0;
    endcase
    return {dz, r[15:0]};
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge the result appears
  task automatic run_txn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input logic exp_dz, input int exp_lat,
                         input string name);
    int w = 0;
    int lat = 0;
    bus.operation = op;
    bus.operand1  = a;
    bus.operand2  = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (!bus.in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      check({name, " busy in_ready"}, 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1; lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " alu_out"}, 32'(bus.alu_out), 32'(exp));
    check({name, " div_zero"}, 32'(bus.div_zero), 32'(exp_dz));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] m;
    logic [3:0]  rop;
    logic [7:0]  ra;
    logic [7:0]  rb;
    int          hits;

    vecs[0]  = '{OP_ADD,  8'hFF, 8'h01, 16'h0100, 1'b0, 4'd0};
    vecs[1]  = '{OP_SUB,  8'h01, 8'h02, 16'hFFFF, 1'b0, 4'd0};
    vecs[2]  = '{OP_MUL,  8'hFF, 8'hFF, 16'hFE01, 1'b0, 4'd0};
    vecs[3]  = '{OP_DIV,  8'd200, 8'd7, 16'd28,   1'b0, 4'd8};
    vecs[4]  = '{OP_MOD,  8'd200, 8'd7, 16'd4,    1'b0, 4'd8};
    vecs[5]  = '{OP_DIV,  8'h05, 8'h00, 16'h00FF, 1'b1, 4'd0};
    vecs[6]  = '{OP_MOD,  8'h05, 8'h00, 16'h0005, 1'b1, 4'd0};
    vecs[7]  = '{OP_AND,  8'hF0, 8'h3C, 16'h0030, 1'b0, 4'd0};
    vecs[8]  = '{OP_OR,   8'hF0, 8'h3C, 16'h00FC, 1'b0, 4'd0};
    vecs[9]  = '{OP_XOR,  8'hF0, 8'h3C, 16'h00CC, 1'b0, 4'd0};
    vecs[10] = '{OP_LAND, 8'h00, 8'h05, 16'h0000, 1'b0, 4'd0};
    vecs[11] = '{OP_LOR,  8'h00, 8'h05, 16'h0001, 1'b0, 4'd0};
    vecs[12] = '{OP_SHL,  8'h81, 8'h00, 16'h0102, 1'b0, 4'd0};
    vecs[13] = '{OP_SHR,  8'h81, 8'h00, 16'h0040, 1'b0, 4'd0};
    vecs[14] = '{OP_EQ,   8'h5A, 8'h5A, 16'h0001, 1'b0, 4'd0};
    vecs[15] = '{OP_NE,   8'h5A, 8'h5A, 16'h0000, 1'b0, 4'd0};
    vecs[16] = '{OP_LT,   8'h03, 8'h04, 16'h0001, 1'b0, 4'd0};
    vecs[17] = '{OP_GT,   8'h03, 8'h04, 16'h0000, 1'b0, 4'd0};
    vecs[18] = '{OP_DIV,  8'hFF, 8'h01, 16'h00FF, 1'b0, 4'd8};
    vecs[19] = '{OP_MOD,  8'h07, 8'hC8, 16'h0007, 1'b0, 4'd8};

    bus.in_valid  = 1'b0;
    bus.operand1  = 8'h00;
    bus.operand2  = 8'h00;
    bus.operation = 4'h0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("post-reset out_valid", 32'(bus.out_valid), 32'd0);
    check("post-reset in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 20; i++) begin
      run_txn(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].dz,
              int'(vecs[i].lat), $sformatf("vec%0d", i));
    end

    // Reset while a result is held
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst alu_out", 32'(bus.alu_out), 32'd0);
    check("rst div_zero", 32'(bus.div_zero), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("release in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // Stalled output, then consume and accept in the same cycle
    bus.operation = 4'h0; bus.operand1 = 8'h12; bus.operand2 = 8'h34;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    check("stall first in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.operation = 4'h7; bus.operand1 = 8'hF0; bus.operand2 = 8'h3C;
    for (int k = 0; k < 3; k++) begin
      check("stall out_valid", 32'(bus.out_valid), 32'd1);
      check("stall alu_out", 32'(bus.alu_out), 32'h0046);
      check("stall in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    check("pulse in_ready", 32'(bus.in_ready), 32'd1);
    check("pulse held alu_out", 32'(bus.alu_out), 32'h0046);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("pulse new out_valid", 32'(bus.out_valid), 32'd1);
    check("pulse new alu_out", 32'(bus.alu_out), 32'h00CC);
    @(posedge clk); #1;
    check("no duplicate out_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a divide
    bus.operation = 4'h3; bus.operand1 = 8'hFF; bus.operand2 = 8'h03;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    check("div abort in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    check("abort in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.out_valid) hits++;
      @(posedge clk); #1;
    end
    check("abort no stray result", 32'(hits), 32'd0);
    run_txn(4'h0, 8'h01, 8'h01, 16'h0002, 1'b0, 0, "after-abort add");

    // Random transactions against the reference model
    for (int i = 0; i < 120; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rb = 8'h00;
      m = model(rop, ra, rb);
      run_txn(rop, ra, rb, m[15:0], m[16],
              ((rop == 4'h3 || rop == 4'h4) && rb != 8'h00) ? N : 0,
              $sformatf("rand%0d op%0h %0h,%0h", i, rop, ra, rb));
    end

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
